pc_bus: RTL and testbench
=========================

# pc_bus

Program-counter and branch unit on the 24-bit transport bus; sits directly downstream of the compare unit and consumes its `cmp_true` flag to resolve conditional branches. Holds the fetch address, accepts jump/branch/call/return moves from the bus, and can drive the current PC onto the bus for link or debug reads. It also emits a one-cycle `flush` to the fetch stage after every taken control transfer. An optional hardware return stack holds call return addresses.

## Interface
- `RESET_PC`, 24'h000000, PC value loaded on reset
- `STACK_DEPTH`, 8, return-stack entries (power of two, 2..64); ignored without `PC_CALL_STACK_EN`
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op_sel`  in  4  move select for this unit (encodings below)
- `bus`  inout  24  shared transport bus; driven only on `out_pc`, else 24'hZ
- `cmp_true`  in  1  compare-unit result flag (1 = condition true)
- `stall`  in  1  freeze: no state, PC or stack change while high
- `pc`  out  24  registered fetch address
- `flush`  out  1  registered; high for exactly one unstalled cycle after a taken transfer
- `fault`  out  1  registered, sticky return-stack over/underflow indicator

## Operation
- `op_sel` encodings: 4'h0 idle; 4'h1 `in_jmp`; 4'h2 `in_bt` (branch if true); 4'h3 `in_bf` (branch if false); 4'h4 `in_call`; 4'h5 `ret`; 4'h8 `out_pc`; all other codes invalid.
- States: RUN, FLUSH, FAULT. Reset → RUN.
- RUN, `stall`=0:
  - idle, `out_pc`, not-taken branch, invalid code: `pc <= pc + 1`; stay RUN. Invalid code prints a simulation warning.
  - `in_jmp`: `pc <= bus`; → FLUSH.
  - `in_bt`: `cmp_true`=1 → `pc <= bus`, → FLUSH; else `pc + 1`.
  - `in_bf`: `cmp_true`=0 → `pc <= bus`, → FLUSH; else `pc + 1`.
  - `in_call` and `ret`: see Configuration.
- FLUSH, `stall`=0: `pc <= pc + 1`; all ops ignored, with no bus sampling and no stack change; `out_pc` still drives the bus; → RUN.
- FAULT: `pc` frozen; `fault`=1; ops ignored except `out_pc` drive; exits only through `rst`.
- `stall`=1 in any state: all registers hold, including the state, `flush`, stack and SP. The `out_pc` bus drive still follows `op_sel`.
- Arithmetic: `pc + 1` is modulo 2^24, so 24'hFFFFFF → 24'h000000. Branch targets are the full 24-bit bus value, with no offset.
- `flush` = 1 iff the state is FLUSH.

## Timing
- Reset values: `pc`=`RESET_PC`, `flush`=0, `fault`=0, SP=0, state RUN, `bus` released. Stack contents are don't-care.
- `bus`, `op_sel` and `cmp_true` are sampled at the rising edge. The new `pc` is visible the cycle after the move, giving 1-cycle transfer latency.
- `out_pc` is combinational. `bus` = current registered `pc` while `op_sel`==4'h8; Z otherwise.
- `cmp_true` must be stable in the cycle the branch move is presented. The compare result registered in cycle N is usable by a branch in cycle N+1.
- `rst` has priority over `stall` and all ops. Reset during FLUSH or FAULT returns to RUN on the next edge.

## Configuration
- `PC_CALL_STACK_EN` defined:
  - `in_call` pushes `pc + 1` (wrapped), sets `pc <= bus`, SP+1, → FLUSH.
  - `ret` pops to `pc`, SP−1, → FLUSH.
  - Push with SP==`STACK_DEPTH` → FAULT, with no write and SP unchanged.
  - Pop with SP==0 → FAULT.
- `PC_CALL_STACK_EN` undefined:
  - No stack or SP storage.
  - 4'h4 and 4'h5 are treated as invalid codes: `pc + 1`, warning.
  - `fault` is tied to 0 and FAULT is unreachable.

## Test plan
- Reset with `RESET_PC`=24'h000010, then 3 idle cycles → `pc` reads 10, 11, 12, 13; `flush`=0; `bus` Z.
- `pc`=24'h000020, `in_bt`, bus=24'h000100, `cmp_true`=1 → next `pc`=24'h000100 and `flush`=1 for one cycle, then `pc`=24'h000101. Repeat with `cmp_true`=0 → `pc`=24'h000021, `flush` stays 0.
- `pc`=24'hFFFFFF, idle → `pc`=24'h000000. `op_sel`=4'h8 at `pc`=24'h000005 → bus reads 24'h000005 in the same cycle.
- `in_jmp` bus=24'h000040 with `stall`=1 held 3 cycles → `pc` unchanged and no flush; `stall` drops with op idle → `pc` increments only.
- With `PC_CALL_STACK_EN`: `in_call` at `pc`=24'h000030 with target 24'h000200, then `ret` after FLUSH → `pc` returns to 24'h000031.
- With `PC_CALL_STACK_EN`: 9 nested calls at `STACK_DEPTH`=8 → `fault`=1 and `pc` frozen; assert `rst` → `fault`=0, `pc`=`RESET_PC`. A `ret` at SP=0 → `fault`=1.

Source files
------------

// File: rtl/pc_bus.sv
`default_nettype none
// ============================================================================
//  Module   : pc_bus
//  Brief    : Program counter and branch unit on the 24-bit transport bus.
//             Accepts jump / conditional branch / call / return moves, can
//             drive the current PC onto the bus, and pulses flush after
//             every taken control transfer.
//             Optional return stack enabled by defining PC_CALL_STACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pc_bus #(
    parameter logic [23:0] RESET_PC    = 24'h000000,
    parameter int          STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_sel,
    inout  wire  [23:0] bus,
    input  logic        cmp_true,
    input  logic        stall,
    output logic [23:0] pc,
    output logic        flush,
    output logic        fault
);

    localparam logic [3:0] c_op_idle = 4'h0;
    localparam logic [3:0] c_op_jmp  = 4'h1;
    localparam logic [3:0] c_op_bt   = 4'h2;
    localparam logic [3:0] c_op_bf   = 4'h3;
    localparam logic [3:0] c_op_out  = 4'h8;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_flush = 2'd1;
    localparam logic [1:0] c_st_fault = 2'd2;

    // Depth must be a power of two in 2..64; caught at elaboration.
    if (STACK_DEPTH < 2 || STACK_DEPTH > 64 ||
        (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_bus: STACK_DEPTH must be a power of two in 2..64");
    end

    logic [1:0]  r_state;
    logic [23:0] r_pc;
    logic [1:0]  w_state_nxt;
    logic [23:0] w_pc_nxt;
    logic [23:0] w_pc_inc;
    logic        w_invalid;

    assign w_pc_inc = r_pc + 24'd1;   // wraps modulo 2^24

    // PC is driven onto the bus only while out_pc is selected, in any state.
    assign bus   = (op_sel == c_op_out) ? r_pc : {24{1'bz}};
    assign pc    = r_pc;
    assign flush = (r_state == c_st_flush);

`ifdef PC_CALL_STACK_EN
    localparam int         SPW       = $clog2(STACK_DEPTH) + 1;
    localparam logic [3:0] c_op_call = 4'h4;
    localparam logic [3:0] c_op_ret  = 4'h5;
    localparam logic [SPW-1:0] c_sp_full = SPW'(STACK_DEPTH);

    logic [23:0]    r_stack [STACK_DEPTH];
    logic [SPW-1:0] r_sp;
    logic [SPW-1:0] w_sp_nxt;
    logic [SPW-1:0] w_sp_dec;
    logic           w_push;

    assign w_sp_dec = r_sp - 1'b1;
    assign fault    = (r_state == c_st_fault);
`else
    assign fault = 1'b0;
`endif

    // Next state / next PC / stack pointer decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_invalid   = 1'b0;
`ifdef PC_CALL_STACK_EN
        w_sp_nxt    = r_sp;
        w_push      = 1'b0;
`endif
        if (!stall) begin
            case (r_state)
                c_st_run: begin
                    w_pc_nxt = w_pc_inc;
                    case (op_sel)
                        c_op_idle, c_op_out: ;
                        c_op_jmp: begin
                            w_pc_nxt    = bus;
                            w_state_nxt = c_st_flush;
                        end
                        c_op_bt: begin
                            if (cmp_true) begin
                                w_pc_nxt    = bus;
                                w_state_nxt = c_st_flush;
                            end
                        end
                        c_op_bf: begin
                            if (!cmp_true) begin
                                w_pc_nxt    = bus;
                                w_state_nxt = c_st_flush;
                            end
                        end
`ifdef PC_CALL_STACK_EN
                        c_op_call: begin
                            if (r_sp == c_sp_full) begin
                                // Overflow: freeze PC, no write.
                                w_pc_nxt    = r_pc;
                                w_state_nxt = c_st_fault;
                            end else begin
                                w_push      = 1'b1;
                                w_sp_nxt    = r_sp + 1'b1;
                                w_pc_nxt    = bus;
                                w_state_nxt = c_st_flush;
                            end
                        end
                        c_op_ret: begin
                            if (r_sp == '0) begin
                                w_pc_nxt    = r_pc;
                                w_state_nxt = c_st_fault;
                            end else begin
                                w_sp_nxt    = w_sp_dec;
                                w_pc_nxt    = r_stack[w_sp_dec[SPW-2:0]];
                                w_state_nxt = c_st_flush;
                            end
                        end
`endif
                        default: w_invalid = 1'b1;
                    endcase
                end
                c_st_flush: begin
                    // Ops ignored here; the bus is not sampled.
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = c_st_run;
                end
                c_st_fault: ;
                default: w_state_nxt = c_st_run;
            endcase
        end
    end

    // State and PC registers; reset overrides stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef PC_CALL_STACK_EN
    // Stack pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else begin
            r_sp <= w_sp_nxt;
        end
    end

    // Return-address storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[r_sp[SPW-2:0]] <= w_pc_inc;
        end
    end
`endif

`ifndef SYNTHESIS
    // Flag invalid move codes seen while running.
    always_ff @(posedge clk) begin
        if (!rst && w_invalid) begin
            $warning("pc_bus: invalid op_sel %h ignored", op_sel);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_bus
//  Brief    : Directed, table-driven self-checking bench for pc_bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_bus;

    localparam logic [23:0] c_reset_pc = 24'h000010;

    logic        clk;
    logic        rst;
    logic [3:0]  op_sel;
    logic        cmp_true;
    logic        stall;
    logic [23:0] pc;
    logic        flush;
    logic        fault;
    logic        tb_en;
    logic [23:0] tb_val;
    wire  [23:0] bus;

    assign bus = tb_en ? tb_val : {24{1'bz}};

    pc_bus #(
        .RESET_PC    (c_reset_pc),
        .STACK_DEPTH (8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .op_sel   (op_sel),
        .bus      (bus),
        .cmp_true (cmp_true),
        .stall    (stall),
        .pc       (pc),
        .flush    (flush),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [23:0] bv;
        logic        cmp;
        logic        stl;
        logic [23:0] epc;
        logic        efl;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] op, input logic [23:0] bv,
                                input logic cmp, input logic stl,
                                input logic [23:0] epc, input logic efl);
        vec_t v;
        v.op = op; v.bv = bv; v.cmp = cmp; v.stl = stl; v.epc = epc; v.efl = efl;
        vecs.push_back(v);
    endfunction

    // Present one move for one cycle, then check PC/flush after the edge.
    task automatic step(input logic [3:0] op, input logic [23:0] bv, input logic cmp,
                        input logic stl, input logic [23:0] epc, input logic efl,
                        input string name);
        op_sel   = op;
        tb_en    = (op != 4'h8);
        tb_val   = bv;
        cmp_true = cmp;
        stall    = stl;
        @(negedge clk);
        chk({name, ".pc"}, pc, epc);
        chk({name, ".flush"}, {23'd0, flush}, {23'd0, efl});
    endtask

    task automatic do_reset;
        rst = 1'b1; op_sel = 4'h0; tb_en = 1'b0; stall = 1'b0; cmp_true = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        tb_val = '0;
        do_reset();
        chk("reset.pc", pc, c_reset_pc);
        chk("reset.flush", {23'd0, flush}, 24'd0);
        chk("reset.fault", {23'd0, fault}, 24'd0);

        // op, bus, cmp, stall, expected pc, expected flush
        add(4'h0, 24'h0, 0, 0, 24'h000011, 0);
        add(4'h0, 24'h0, 0, 0, 24'h000012, 0);
        add(4'h0, 24'h0, 0, 0, 24'h000013, 0);
        add(4'h1, 24'h00001F, 0, 0, 24'h00001F, 1);
        add(4'h0, 24'h0, 0, 0, 24'h000020, 0);
        add(4'h2, 24'h000100, 1, 0, 24'h000100, 1);   // bt taken
        add(4'h0, 24'h0, 0, 0, 24'h000101, 0);
        add(4'h1, 24'h00001F, 0, 0, 24'h00001F, 1);
        add(4'h0, 24'h0, 0, 0, 24'h000020, 0);
        add(4'h2, 24'h000100, 0, 0, 24'h000021, 0);   // bt not taken
        add(4'h3, 24'h000300, 1, 0, 24'h000022, 0);   // bf not taken
        add(4'h3, 24'h000300, 0, 0, 24'h000300, 1);   // bf taken
        add(4'h1, 24'h000500, 0, 0, 24'h000301, 0);   // jmp ignored in FLUSH
        add(4'h7, 24'h0, 0, 0, 24'h000302, 0);        // invalid code
        add(4'h8, 24'h0, 0, 0, 24'h000303, 0);        // out_pc advances
`ifndef PC_CALL_STACK_EN
        add(4'h4, 24'h000777, 0, 0, 24'h000304, 0);   // call invalid here
        add(4'h5, 24'h0, 0, 0, 24'h000305, 0);        // ret invalid here
`endif
        add(4'h1, 24'hFFFFFE, 0, 0, 24'hFFFFFE, 1);
        add(4'h0, 24'h0, 0, 0, 24'hFFFFFF, 0);
        add(4'h0, 24'h0, 0, 0, 24'h000000, 0);        // RUN wrap
        add(4'h1, 24'hFFFFFF, 0, 0, 24'hFFFFFF, 1);
        add(4'h0, 24'h0, 0, 0, 24'h000000, 0);        // FLUSH wrap
        add(4'h1, 24'h000040, 0, 1, 24'h000000, 0);   // stalled jmp
        add(4'h1, 24'h000040, 0, 1, 24'h000000, 0);
        add(4'h1, 24'h000040, 0, 1, 24'h000000, 0);
        add(4'h0, 24'h0, 0, 0, 24'h000001, 0);
        add(4'h1, 24'h000050, 0, 0, 24'h000050, 1);
        add(4'h0, 24'h0, 0, 1, 24'h000050, 1);        // stall holds FLUSH
        add(4'h0, 24'h0, 0, 1, 24'h000050, 1);
        add(4'h0, 24'h0, 0, 0, 24'h000051, 0);

        foreach (vecs[i]) begin
            op_sel   = vecs[i].op;
            tb_en    = (vecs[i].op != 4'h8);
            tb_val   = vecs[i].bv ^ 24'h5A0000;   // distinctive value while idle
            if (vecs[i].op != 4'h0) tb_val = vecs[i].bv;
            cmp_true = vecs[i].cmp;
            stall    = vecs[i].stl;
            #1;
            if (vecs[i].op != 4'h8) chk($sformatf("v%0d.bus_released", i), bus, tb_val);
            @(negedge clk);
            chk($sformatf("v%0d.pc", i), pc, vecs[i].epc);
            chk($sformatf("v%0d.flush", i), {23'd0, flush}, {23'd0, vecs[i].efl});
            chk($sformatf("v%0d.fault", i), {23'd0, fault}, 24'd0);
        end

        // out_pc drives the current PC combinationally, in the same cycle.
        step(4'h1, 24'h000004, 0, 0, 24'h000004, 1, "outpc.jmp");
        op_sel = 4'h8; tb_en = 1'b0; #1;
        chk("outpc.flush_drive", bus, 24'h000004);
        @(negedge clk);
        chk("outpc.pc", pc, 24'h000005);
        #1;
        chk("outpc.bus", bus, 24'h000005);
        stall = 1'b1; #1;
        chk("outpc.bus_stalled", bus, 24'h000005);
        @(negedge clk);
        chk("outpc.pc_stalled", pc, 24'h000005);
        stall = 1'b0;

`ifdef PC_CALL_STACK_EN
        // Call then return.
        do_reset();
        step(4'h1, 24'h000030, 0, 0, 24'h000030, 1, "call.jmp");
        step(4'h0, 24'h0, 0, 0, 24'h000031, 0, "call.fl0");
        step(4'h1, 24'h000030, 0, 0, 24'h000030, 1, "call.jmp2");
        step(4'h0, 24'h0, 0, 0, 24'h000031, 0, "call.fl1");
        step(4'h1, 24'h00002F, 0, 0, 24'h00002F, 1, "call.jmp3");
        step(4'h0, 24'h0, 0, 0, 24'h000030, 0, "call.fl2");
        step(4'h4, 24'h000200, 0, 0, 24'h000200, 1, "call.call");
        step(4'h0, 24'h0, 0, 0, 24'h000201, 0, "call.fl3");
        step(4'h5, 24'h0, 0, 0, 24'h000031, 1, "call.ret");
        step(4'h0, 24'h0, 0, 0, 24'h000032, 0, "call.fl4");

        // Overflow after 8 nested calls.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'h4, 24'h000100 * (k + 1), 0, 0, 24'h000100 * (k + 1), 1, "ovf.call");
            step(4'h0, 24'h0, 0, 0, 24'h000100 * (k + 1) + 24'd1, 0, "ovf.fl");
        end
        step(4'h4, 24'h000F00, 0, 0, 24'h000801, 0, "ovf.call9");
        chk("ovf.fault", {23'd0, fault}, 24'd1);
        step(4'h1, 24'h000123, 0, 0, 24'h000801, 0, "ovf.frozen");
        chk("ovf.fault_sticky", {23'd0, fault}, 24'd1);
        do_reset();
        chk("ovf.rst_fault", {23'd0, fault}, 24'd0);
        chk("ovf.rst_pc", pc, c_reset_pc);

        // Underflow.
        step(4'h5, 24'h0, 0, 0, c_reset_pc, 0, "unf.ret");
        chk("unf.fault", {23'd0, fault}, 24'd1);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
